// File: rtl/hazard_unit_p.sv
// Pipeline hazard controller for the 5-stage MIPS core: operand forwarding, stage stall/flush,
// mult/div latency tracking, deferred exception issue and a saturating stall counter.
module hazard_unit_p #(
  parameter int unsigned REGW     = 5,
  parameter int unsigned MULT_LAT = 4,
  parameter int unsigned DIV_LAT  = 32,
  parameter int unsigned CNTW     = 16
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [REGW-1:0] rsD,
  input  logic [REGW-1:0] rtD,
  input  logic [REGW-1:0] rsE,
  input  logic [REGW-1:0] rtE,
  input  logic [REGW-1:0] writeregE,
  input  logic [REGW-1:0] writeregM,
  input  logic [REGW-1:0] writeregW,
  input  logic            regwriteE,
  input  logic            regwriteM,
  input  logic            regwriteW,
  input  logic            memtoregE,
  input  logic            memtoregM,
  input  logic            branchD,
  input  logic            jumpregD,
  input  logic            instrackF,
  input  logic            dataackM,
  input  logic            hiloaccessD,
  input  logic            mdstartE,
  input  logic            mddivE,
  input  logic            exceptionM,
  input  logic            cntclear,
  output logic            forwardAD,
  output logic            forwardBD,
  output logic [1:0]      forwardAE,
  output logic [1:0]      forwardBE,
  output logic            stallF,
  output logic            stallD,
  output logic            stallE,
  output logic            stallM,
  output logic            stallW,
  output logic            flushD,
  output logic            flushE,
  output logic            flushM,
  output logic            activeexception,
  output logic            mdbusy,
  output logic [CNTW-1:0] stallcount
);

  localparam int unsigned MDW = $clog2(DIV_LAT + 1);

  typedef enum logic {StIdle, StPend} exc_state_e;

  exc_state_e      excStateQ, excStateD;
  logic [MDW-1:0]  mdCntQ, mdCntD;
  logic [CNTW-1:0] stallCntQ, stallCntD;

  logic lwstall, brstall, mdstall, instrmiss, datamiss, memstall;

  // Register 0 is hardwired, so a write to it never creates a dependency.
  function automatic logic hit(input logic we, input logic [REGW-1:0] dst,
                               input logic [REGW-1:0] src);
    return we && (dst != '0) && (dst == src);
  endfunction

  always_comb begin
    forwardAE = hit(regwriteM, writeregM, rsE) ? 2'b10 :
                hit(regwriteW, writeregW, rsE) ? 2'b01 : 2'b00;
    forwardBE = hit(regwriteM, writeregM, rtE) ? 2'b10 :
                hit(regwriteW, writeregW, rtE) ? 2'b01 : 2'b00;
    forwardAD = hit(regwriteM, writeregM, rsD);
    forwardBD = hit(regwriteM, writeregM, rtD);

    lwstall = hit(memtoregE, writeregE, rsD) | hit(memtoregE, writeregE, rtD);
    brstall = (branchD | jumpregD) &
              (hit(regwriteE, writeregE, rsD) | hit(regwriteE, writeregE, rtD) |
               hit(memtoregM, writeregM, rsD) | hit(memtoregM, writeregM, rtD));

    instrmiss = ~instrackF;
    datamiss  = ~dataackM;
    memstall  = instrmiss | datamiss;
    mdbusy    = (mdCntQ != '0);
    mdstall   = hiloaccessD & (mdbusy | mdstartE);

    stallD = lwstall | brstall | mdstall | memstall;
    stallF = stallD;
    stallE = memstall;
    stallM = datamiss;
    stallW = datamiss;

    activeexception = (exceptionM | (excStateQ == StPend)) & ~memstall;

    flushD = activeexception;
    flushE = (stallD & ~memstall) | activeexception;
    flushM = (memstall & ~datamiss) | activeexception;
  end

  // A new issue always reloads, so a back-to-back mult/div restarts the latency window.
  always_comb begin
    mdCntD = mdCntQ;
    if (mdstartE && !stallE) begin
      mdCntD = mddivE ? MDW'(DIV_LAT) : MDW'(MULT_LAT);
    end else if (mdCntQ != '0) begin
      mdCntD = mdCntQ - MDW'(1);
    end
  end

  always_comb begin
    excStateD = excStateQ;
    unique case (excStateQ)
      StIdle: if (exceptionM && memstall) excStateD = StPend;
      StPend: if (!memstall) excStateD = StIdle;
      default: excStateD = StIdle;
    endcase
  end

  always_comb begin
    stallCntD = stallCntQ;
    if (cntclear) begin
      stallCntD = '0;
    end else if (stallD && (stallCntQ != '1)) begin
      stallCntD = stallCntQ + CNTW'(1);
    end
  end

  assign stallcount = stallCntQ;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      excStateQ <= StIdle;
      mdCntQ    <= '0;
      stallCntQ <= '0;
    end else begin
      excStateQ <= excStateD;
      mdCntQ    <= mdCntD;
      stallCntQ <= stallCntD;
    end
  end

endmodule

// File: tb/tb_hazard_unit_p.sv
// Directed bench for hazard_unit_p: a combinational vector table plus hand-written sequences
// for mult/div latency, deferred exceptions, stall counter saturation and reset.
module tb_hazard_unit_p;

  localparam int unsigned CNTW = 8;

  logic clk = 1'b0;
  logic reset;
  logic [4:0] rsD, rtD, rsE, rtE, writeregE, writeregM, writeregW;
  logic regwriteE, regwriteM, regwriteW, memtoregE, memtoregM, branchD, jumpregD;
  logic instrackF, dataackM, hiloaccessD, mdstartE, mddivE, exceptionM, cntclear;
  logic forwardAD, forwardBD;
  logic [1:0] forwardAE, forwardBE;
  logic stallF, stallD, stallE, stallM, stallW, flushD, flushE, flushM;
  logic activeexception, mdbusy;
  logic [CNTW-1:0] stallcount;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  hazard_unit_p #(
    .REGW(5), .MULT_LAT(4), .DIV_LAT(32), .CNTW(CNTW)
  ) dut (
    .clk(clk), .reset(reset),
    .rsD(rsD), .rtD(rtD), .rsE(rsE), .rtE(rtE),
    .writeregE(writeregE), .writeregM(writeregM), .writeregW(writeregW),
    .regwriteE(regwriteE), .regwriteM(regwriteM), .regwriteW(regwriteW),
    .memtoregE(memtoregE), .memtoregM(memtoregM),
    .branchD(branchD), .jumpregD(jumpregD),
    .instrackF(instrackF), .dataackM(dataackM), .hiloaccessD(hiloaccessD),
    .mdstartE(mdstartE), .mddivE(mddivE), .exceptionM(exceptionM), .cntclear(cntclear),
    .forwardAD(forwardAD), .forwardBD(forwardBD),
    .forwardAE(forwardAE), .forwardBE(forwardBE),
    .stallF(stallF), .stallD(stallD), .stallE(stallE), .stallM(stallM), .stallW(stallW),
    .flushD(flushD), .flushE(flushE), .flushM(flushM),
    .activeexception(activeexception), .mdbusy(mdbusy), .stallcount(stallcount)
  );

  typedef struct {
    string      name;
    logic [4:0] rsD, rtD, rsE, rtE, wE, wM, wW;
    logic       rwE, rwM, rwW, mtrE, mtrM, br, jr, iack, dack, hilo, exc;
    // {AE[1:0], BE[1:0], AD, BD, stF, stD, stE, stM, stW, flD, flE, flM, activeexception}
    logic [14:0] exp;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t idleVec(input string name);
    vec_t v;
    v.name = name;
    v.rsD = 0; v.rtD = 0; v.rsE = 0; v.rtE = 0; v.wE = 0; v.wM = 0; v.wW = 0;
    v.rwE = 0; v.rwM = 0; v.rwW = 0; v.mtrE = 0; v.mtrM = 0; v.br = 0; v.jr = 0;
    v.iack = 1; v.dack = 1; v.hilo = 0; v.exc = 0;
    v.exp = '0;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic setIdle();
    rsD = 0; rtD = 0; rsE = 0; rtE = 0; writeregE = 0; writeregM = 0; writeregW = 0;
    regwriteE = 0; regwriteM = 0; regwriteW = 0; memtoregE = 0; memtoregM = 0;
    branchD = 0; jumpregD = 0; instrackF = 1; dataackM = 1; hiloaccessD = 0;
    mdstartE = 0; mddivE = 0; exceptionM = 0; cntclear = 0;
  endtask

  task automatic applyVec(input vec_t v);
    setIdle();
    rsD = v.rsD; rtD = v.rtD; rsE = v.rsE; rtE = v.rtE;
    writeregE = v.wE; writeregM = v.wM; writeregW = v.wW;
    regwriteE = v.rwE; regwriteM = v.rwM; regwriteW = v.rwW;
    memtoregE = v.mtrE; memtoregM = v.mtrM; branchD = v.br; jumpregD = v.jr;
    instrackF = v.iack; dataackM = v.dack; hiloaccessD = v.hilo; exceptionM = v.exc;
  endtask

  function automatic logic [14:0] obs();
    return {forwardAE, forwardBE, forwardAD, forwardBD, stallF, stallD, stallE, stallM, stallW,
            flushD, flushE, flushM, activeexception};
  endfunction

  initial begin
    vec_t v;

    v = idleVec("idle");                                              vecs.push_back(v);
    v = idleVec("fwdAE_M_priority");
    v.wM = 7; v.wW = 7; v.rsE = 7; v.rwM = 1; v.rwW = 1;
    v.exp = 15'b10_00_00_00000_000_0;                                 vecs.push_back(v);
    v = idleVec("fwdAE_W_when_wM0");
    v.wM = 0; v.wW = 7; v.rsE = 7; v.rwM = 1; v.rwW = 1;
    v.exp = 15'b01_00_00_00000_000_0;                                 vecs.push_back(v);
    v = idleVec("fwdAE_rsE0_BE_M");
    v.wM = 7; v.wW = 7; v.rsE = 0; v.rtE = 7; v.rwM = 1; v.rwW = 1;
    v.exp = 15'b00_10_00_00000_000_0;                                 vecs.push_back(v);
    v = idleVec("fwdBD_from_M");
    v.rsD = 5; v.rtD = 6; v.wM = 6; v.rwM = 1;
    v.exp = 15'b00_00_01_00000_000_0;                                 vecs.push_back(v);
    v = idleVec("fwdAE_W_M_disabled");
    v.rsE = 9; v.wM = 9; v.wW = 9; v.rwW = 1;
    v.exp = 15'b01_00_00_00000_000_0;                                 vecs.push_back(v);
    v = idleVec("lwstall_rtD");
    v.mtrE = 1; v.wE = 3; v.rtD = 3;
    v.exp = 15'b00_00_00_11000_010_0;                                 vecs.push_back(v);
    v = idleVec("lwstall_r0_none");
    v.mtrE = 1; v.wE = 0; v.rsD = 0;                                  vecs.push_back(v);
    v = idleVec("brstall_regwriteE");
    v.br = 1; v.rwE = 1; v.wE = 4; v.rsD = 4;
    v.exp = 15'b00_00_00_11000_010_0;                                 vecs.push_back(v);
    v = idleVec("brstall_jr_loadM");
    v.jr = 1; v.mtrM = 1; v.wM = 8; v.rtD = 8;
    v.exp = 15'b00_00_00_11000_010_0;                                 vecs.push_back(v);
    v = idleVec("branch_fwd_no_stall");
    v.br = 1; v.rwM = 1; v.wM = 2; v.rsD = 2;
    v.exp = 15'b00_00_10_00000_000_0;                                 vecs.push_back(v);
    v = idleVec("instr_miss");
    v.iack = 0;
    v.exp = 15'b00_00_00_11100_001_0;                                 vecs.push_back(v);
    v = idleVec("data_miss");
    v.dack = 0;
    v.exp = 15'b00_00_00_11111_000_0;                                 vecs.push_back(v);
    v = idleVec("exception_quiet");
    v.exc = 1;
    v.exp = 15'b00_00_00_00000_111_1;                                 vecs.push_back(v);
    v = idleVec("hilo_not_busy");
    v.hilo = 1;                                                       vecs.push_back(v);

    // Reset state, with a pending-style exception request held during reset.
    setIdle();
    reset = 1'b0;
    exceptionM = 1; dataackM = 0; mdstartE = 1; mddivE = 1;
    repeat (3) @(negedge clk);
    #1;
    chk("reset_mdbusy", 32'(mdbusy), 32'd0);
    chk("reset_activeexception", 32'(activeexception), 32'd0);
    chk("reset_stallcount", 32'(stallcount), 32'd0);
    @(negedge clk);
    setIdle();
    reset = 1'b1;
    #1;
    chk("post_reset_mdbusy", 32'(mdbusy), 32'd0);

    foreach (vecs[i]) begin
      @(negedge clk);
      applyVec(vecs[i]);
      #1;
      chk(vecs[i].name, 32'(obs()), 32'(vecs[i].exp));
    end

    // Divide with a dependent HI/LO access waiting in D.
    @(negedge clk); setIdle(); mdstartE = 1; mddivE = 1; hiloaccessD = 1; #1;
    chk("div_issue_stallD", 32'(stallD), 32'd1);
    chk("div_issue_mdbusy", 32'(mdbusy), 32'd0);
    for (int i = 1; i <= 32; i++) begin
      @(negedge clk); setIdle(); hiloaccessD = 1; #1;
      if (i == 1 || i == 32) begin
        chk($sformatf("div_busy_c%0d", i), 32'({mdbusy, stallD}), 32'b11);
      end else if (!(mdbusy && stallD)) begin
        chk($sformatf("div_busy_c%0d", i), 32'({mdbusy, stallD}), 32'b11);
      end
    end
    @(negedge clk); setIdle(); hiloaccessD = 1; #1;
    chk("div_done_c33", 32'({mdbusy, stallD}), 32'b00);

    // Multiply: busy for exactly four cycles.
    @(negedge clk); setIdle(); mdstartE = 1; #1;
    for (int i = 1; i <= 4; i++) begin
      @(negedge clk); setIdle(); #1;
      if (i == 4) chk("mult_busy_c4", 32'(mdbusy), 32'd1);
    end
    @(negedge clk); setIdle(); #1;
    chk("mult_done_c5", 32'(mdbusy), 32'd0);

    // Multiply issued two cycles into a divide restarts the window.
    @(negedge clk); setIdle(); mdstartE = 1; mddivE = 1; #1;
    repeat (2) begin @(negedge clk); setIdle(); #1; end
    @(negedge clk); setIdle(); mdstartE = 1; #1;
    chk("restart_busy", 32'(mdbusy), 32'd1);
    for (int i = 1; i <= 4; i++) begin
      @(negedge clk); setIdle(); #1;
      if (i == 4) chk("restart_busy_c4", 32'(mdbusy), 32'd1);
    end
    @(negedge clk); setIdle(); #1;
    chk("restart_done", 32'(mdbusy), 32'd0);

    // Issue blocked by a memory stall does not start the counter.
    @(negedge clk); setIdle(); mdstartE = 1; mddivE = 1; instrackF = 0; #1;
    @(negedge clk); setIdle(); #1;
    chk("stalled_issue_ignored", 32'(mdbusy), 32'd0);

    // Exception during a data miss is held, then fires once.
    for (int i = 0; i < 3; i++) begin
      @(negedge clk); setIdle(); exceptionM = 1; dataackM = 0; #1;
      chk($sformatf("exc_held_c%0d", i), 32'({activeexception, stallM}), 32'b01);
    end
    @(negedge clk); setIdle(); #1;
    chk("exc_fire", 32'({flushD, flushE, flushM, activeexception}), 32'hf);
    @(negedge clk); setIdle(); #1;
    chk("exc_single_pulse", 32'(activeexception), 32'd0);

    // Same, deferred by an instruction miss.
    @(negedge clk); setIdle(); exceptionM = 1; instrackF = 0; #1;
    chk("exc_imiss_held", 32'({activeexception, flushM}), 32'b01);
    @(negedge clk); setIdle(); #1;
    chk("exc_imiss_fire", 32'(activeexception), 32'd1);

    // Stall counter: clear, count, saturate, clear while stalling.
    @(negedge clk); setIdle(); instrackF = 0; cntclear = 1; #1;
    @(negedge clk); setIdle(); instrackF = 0; #1;
    chk("cnt_cleared", 32'(stallcount), 32'd0);
    repeat (2) begin @(negedge clk); setIdle(); instrackF = 0; #1; end
    chk("cnt_two", 32'(stallcount), 32'd2);
    repeat ((1 << CNTW) + 5) begin @(negedge clk); setIdle(); instrackF = 0; #1; end
    chk("cnt_saturated", 32'(stallcount), 32'((1 << CNTW) - 1));
    @(negedge clk); setIdle(); instrackF = 0; cntclear = 1; #1;
    @(negedge clk); setIdle(); #1;
    chk("cnt_clear_priority", 32'(stallcount), 32'd0);

    // Reset mid-divide and mid-pending exception.
    @(negedge clk); setIdle(); mdstartE = 1; mddivE = 1; #1;
    repeat (5) begin @(negedge clk); setIdle(); #1; end
    chk("middiv_busy", 32'(mdbusy), 32'd1);
    @(negedge clk); setIdle(); exceptionM = 1; dataackM = 0; #1;
    @(negedge clk); setIdle(); dataackM = 0; reset = 1'b0; #1;
    chk("reset_middiv", 32'(mdbusy), 32'd0);
    @(negedge clk); setIdle(); reset = 1'b1; #1;
    chk("reset_drops_pending", 32'({activeexception, mdbusy}), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
